// File: rtl/sprite_fetcher_multi_if.sv
// Bus bundle for the multi-sprite fetcher: line/scan inputs, shared memory port and FIFO push.
// master is the fetcher side; slave is the surrounding PPU (scan buffer, memory, sprite FIFO).
interface sprite_fetcher_multi_if #(
  parameter int unsigned X_MAX = 160,
  parameter int unsigned SLOTS = 10
);
  localparam int unsigned XW = $clog2(X_MAX);
  localparam int unsigned CW = $clog2(SLOTS + 1);

  logic                  tclk_in;
  logic                  line_start_in;
  logic [XW-1:0]         X_in;
  logic                  sprite_ena_in;
  logic                  tall_sprite_mode_in;
  logic [18*SLOTS-1:0]   sprite_buffer_in;
  logic [CW-1:0]         sprite_count_in;
  logic                  sprite_detected_out;
  logic                  mem_free_in;
  logic [15:0]           addr_out;
  logic                  addr_valid_out;
  logic [7:0]            data_in;
  logic                  data_valid_in;
  logic                  sprite_fifo_ready_in;
  logic                  valid_pixels_out;
  logic [15:0]           pixels_out;
  logic [7:0]            palette_out;
  logic [7:0]            priority_out;
  logic [3:0]            discard_out;

  modport master (
    input  tclk_in, line_start_in, X_in, sprite_ena_in, tall_sprite_mode_in,
    input  sprite_buffer_in, sprite_count_in, mem_free_in, data_in, data_valid_in,
    input  sprite_fifo_ready_in,
    output sprite_detected_out, addr_out, addr_valid_out, valid_pixels_out,
    output pixels_out, palette_out, priority_out, discard_out
  );

  modport slave (
    output tclk_in, line_start_in, X_in, sprite_ena_in, tall_sprite_mode_in,
    output sprite_buffer_in, sprite_count_in, mem_free_in, data_in, data_valid_in,
    output sprite_fifo_ready_in,
    input  sprite_detected_out, addr_out, addr_valid_out, valid_pixels_out,
    input  pixels_out, palette_out, priority_out, discard_out
  );
endinterface

// File: rtl/sprite_fetcher_multi.sv
// Multi-sprite PPU fetcher: services every line-buffer hit in slot order, reading tile, flags and
// two tile-row bytes over a shared memory port and pushing 8 decoded pixels into the sprite FIFO.
module sprite_fetcher_multi #(
  parameter int unsigned X_MAX   = 160,
  parameter int unsigned SLOTS   = 10,
  parameter int unsigned TIMEOUT = 4
) (
  input logic                    clk_in,
  input logic                    rst_n_in,
  sprite_fetcher_multi_if.master bus
);
  localparam int unsigned XW  = $clog2(X_MAX);
  localparam int unsigned CW  = $clog2(SLOTS + 1);
  localparam int unsigned SIW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned TW  = $clog2(TIMEOUT + 1);
  localparam int unsigned SW  = ((XW > 8) ? XW : 8) + 1;

  typedef enum logic [2:0] {
    StIdle, StReqTile, StReqFlags, StReqLo, StReqHi, StPush
  } state_e;

  state_e           state_q, state_d;
  logic [SLOTS-1:0] done_q, done_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [SIW-1:0]   slot_q, slot_d;
  logic [7:0]       sx_q, sx_d;
  logic [5:0]       oam_q, oam_d;
  logic [3:0]       row_q, row_d;
  logic [7:0]       tile_q, tile_d, flags_q, flags_d, lo_q, lo_d, hi_q, hi_d;
  logic             valid_q, valid_d;
  logic [15:0]      pixels_q, pixels_d;
  logic [7:0]       palette_q, palette_d, priority_q, priority_d;
  logic [3:0]       discard_q, discard_d;

  logic [SLOTS-1:0] slot_hit;
  logic             hit;
  logic [SIW-1:0]   hit_slot;
  logic [17:0]      hit_entry;
  logic             is_req, accept;
  logic [7:0]       byte_in, tile_eff;
  logic [3:0]       row_eff;
  logic [15:0]      oam_addr, vram_addr, addr;
  logic [15:0]      pix;

  // Compare at SW bits so sprites near the right edge do not wrap into a false miss.
  always_comb begin
    slot_hit = '0;
    for (int i = 0; i < SLOTS; i++) begin
      slot_hit[i] = (CW'(i) < bus.sprite_count_in) && bus.sprite_ena_in &&
                    (bus.sprite_buffer_in[18*i+10 +: 8] != 8'd0) &&
                    (SW'(bus.sprite_buffer_in[18*i+10 +: 8]) <= SW'(bus.X_in) + SW'(8)) &&
                    !done_q[i];
    end
  end

  always_comb begin
    hit       = 1'b0;
    hit_slot  = '0;
    hit_entry = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (slot_hit[i] && !hit) begin
        hit       = 1'b1;
        hit_slot  = SIW'(i);
        hit_entry = bus.sprite_buffer_in[18*i +: 18];
      end
    end
  end

  assign is_req  = (state_q == StReqTile) || (state_q == StReqFlags) ||
                   (state_q == StReqLo) || (state_q == StReqHi);
  assign accept  = bus.data_valid_in || (timer_q == TW'(TIMEOUT - 1));
  assign byte_in = bus.data_valid_in ? bus.data_in : 8'hFF;

  always_comb begin
    tile_eff = bus.tall_sprite_mode_in ? {tile_q[7:1], 1'b0} : tile_q;
    if (bus.tall_sprite_mode_in) begin
      row_eff = flags_q[6] ? 4'd15 - row_q : row_q;
    end else begin
      row_eff = {1'b0, flags_q[6] ? 3'd7 - row_q[2:0] : row_q[2:0]};
    end
    oam_addr  = 16'hFE02 + {8'h00, oam_q, 2'b00};
    vram_addr = 16'h8000 + {4'h0, tile_eff, 4'h0} + {11'h000, row_eff, 1'b0};
    unique case (state_q)
      StReqTile:  addr = oam_addr;
      StReqFlags: addr = oam_addr + 16'd1;
      StReqLo:    addr = vram_addr;
      StReqHi:    addr = vram_addr + 16'd1;
      default:    addr = 16'h0000;
    endcase
  end

  // Pixel 0 is the leftmost; without X-flip it comes from bit 7.
  always_comb begin
    pix = '0;
    for (int p = 0; p < 8; p++) begin
      pix[2*p +: 2] = flags_q[5] ? {hi_q[p], lo_q[p]} : {hi_q[7-p], lo_q[7-p]};
    end
  end

  always_comb begin
    state_d    = state_q;
    done_d     = done_q;
    timer_d    = timer_q;
    slot_d     = slot_q;
    sx_d       = sx_q;
    oam_d      = oam_q;
    row_d      = row_q;
    tile_d     = tile_q;
    flags_d    = flags_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    valid_d    = 1'b0;
    pixels_d   = pixels_q;
    palette_d  = palette_q;
    priority_d = priority_q;
    discard_d  = discard_q;
    if (bus.tclk_in) begin
      if (bus.line_start_in) begin
        state_d = StIdle;
        done_d  = '0;
        timer_d = '0;
      end else begin
        if (is_req) begin
          timer_d = accept ? '0 : timer_q + 1'b1;
        end
        unique case (state_q)
          StIdle: begin
            if (hit && bus.mem_free_in) begin
              state_d = StReqTile;
              slot_d  = hit_slot;
              sx_d    = hit_entry[17:10];
              oam_d   = hit_entry[9:4];
              row_d   = hit_entry[3:0];
              timer_d = '0;
            end
          end
          StReqTile: if (accept) begin
            tile_d  = byte_in;
            state_d = StReqFlags;
          end
          StReqFlags: if (accept) begin
            flags_d = byte_in;
            state_d = StReqLo;
          end
          StReqLo: if (accept) begin
            lo_d    = byte_in;
            state_d = StReqHi;
          end
          StReqHi: if (accept) begin
            hi_d    = byte_in;
            state_d = StPush;
          end
          StPush: begin
            if (bus.sprite_fifo_ready_in) begin
              valid_d         = 1'b1;
              pixels_d        = pix;
              palette_d       = {8{flags_q[4]}};
              priority_d      = {8{flags_q[7]}};
              discard_d       = (sx_q < 8'd8) ? 4'(8'd8 - sx_q) : 4'd0;
              done_d[slot_q]  = 1'b1;
              state_d         = StIdle;
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= StIdle;
      done_q     <= '0;
      timer_q    <= '0;
      slot_q     <= '0;
      sx_q       <= '0;
      oam_q      <= '0;
      row_q      <= '0;
      tile_q     <= '0;
      flags_q    <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      valid_q    <= 1'b0;
      pixels_q   <= '0;
      palette_q  <= '0;
      priority_q <= '0;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      timer_q    <= timer_d;
      slot_q     <= slot_d;
      sx_q       <= sx_d;
      oam_q      <= oam_d;
      row_q      <= row_d;
      tile_q     <= tile_d;
      flags_q    <= flags_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      valid_q    <= valid_d;
      pixels_q   <= pixels_d;
      palette_q  <= palette_d;
      priority_q <= priority_d;
      discard_q  <= discard_d;
    end
  end

  // Reset forces the stall flag low even though the hit test is combinational on the inputs.
  assign bus.sprite_detected_out = rst_n_in && (hit || (state_q != StIdle));
  assign bus.addr_out            = addr;
  assign bus.addr_valid_out      = is_req;
  assign bus.valid_pixels_out    = valid_q;
  assign bus.pixels_out          = pixels_q;
  assign bus.palette_out         = palette_q;
  assign bus.priority_out        = priority_q;
  assign bus.discard_out         = discard_q;
endmodule
